// File: rtl/matrix_row_scanner_pkg.sv
// Shared constants and types for the 5x7 dot-matrix row scanner.
package matrix_row_scanner_pkg;

  localparam int ROWS   = 7;
  localparam int COLS   = 5;
  localparam int DATA_W = ROWS * COLS;  // row r occupies [COLS*r +: COLS]
  localparam int CNT_W  = 16;           // interval timer width (DWELL/BLANK up to 65536)
  localparam int FRM_W  = 16;           // frame counter width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Active-low one-hot row select for row index r.
  function automatic logic [ROWS-1:0] row_sel_n(input logic [2:0] r);
    return ~(ROWS'(1) << r);
  endfunction

endpackage

// File: rtl/matrix_row_scanner_if.sv
// Signal bundle between the row scanner and its environment.
// There is no valid/ready handshake: en, hold and row_data are level inputs
// sampled on every rising clk edge; all outputs are registered and change only
// on rising edges. state_dbg mirrors the controller FSM state for observation.
interface matrix_row_scanner_if;
  import matrix_row_scanner_pkg::*;

  logic              en;
  logic              hold;
  logic [DATA_W-1:0] row_data;
  logic [1:0]        sym_sel;
  logic [ROWS-1:0]   row_n;
  logic [COLS-1:0]   col;
  logic              frame_tick;
  state_e            state_dbg;

  // Environment side: supplies controls and patterns, observes the display drive.
  modport master (
    output en, hold, row_data,
    input  sym_sel, row_n, col, frame_tick, state_dbg
  );

  // Scanner side.
  modport slave (
    input  en, hold, row_data,
    output sym_sel, row_n, col, frame_tick, state_dbg
  );
endinterface

// File: rtl/matrix_row_scanner_scan_timer.sv
// Loadable down-counter with a terminal-count flag; times DWELL and BLANK
// intervals. tc is high while the count is zero. Load wins over decrement.
module scan_timer
  import matrix_row_scanner_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             tc
);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: load, otherwise decrement towards zero and stop there.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign tc = (count_q == '0);

endmodule

// File: rtl/matrix_row_scanner.sv
// Row-multiplexing controller for a 5x7 dot-matrix: drives one active-low row
// at a time with its column pattern, blanks between rows, and steps the symbol
// select every FRAMES_PER_SYM complete frames.
module matrix_row_scanner
  import matrix_row_scanner_pkg::*;
#(
  parameter int DWELL          = 16,
  parameter int BLANK          = 2,
  parameter int FRAMES_PER_SYM = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  matrix_row_scanner_if.slave   bus
);

  // Timer reload values: the timer counts down to zero, so an interval of N
  // cycles loads N-1.
  localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAMES_PER_SYM - 1);
  localparam logic [2:0]       ROW_LAST = 3'(ROWS - 1);

  state_e            state_q, state_d;
  logic [2:0]        row_q, row_d;
  logic [FRM_W-1:0]  frame_q, frame_d;
  logic [1:0]        sym_q, sym_d;
  logic              tick_q, tick_d;
  logic [ROWS-1:0]   row_n_q, row_n_d;
  logic [COLS-1:0]   col_q, col_d;

  logic              t_load;
  logic [CNT_W-1:0]  t_val;
  logic              t_dec;
  logic              t_tc;

  scan_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .dec      (t_dec),
    .tc       (t_tc)
  );

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    frame_d = frame_q;
    sym_d   = sym_q;
    tick_d  = 1'b0;
    t_load  = 1'b0;
    t_val   = '0;
    t_dec   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.en) begin
          state_d = DRIVE;
          row_d   = '0;
          t_load  = 1'b1;
          t_val   = DWELL_LD;
        end
      end

      DRIVE, GAP: begin
        if (!bus.en) begin
          // Abort: blank, clear row and dwell count, keep frame count and symbol.
          state_d = IDLE;
          row_d   = '0;
          t_load  = 1'b1;
          t_val   = '0;
        end else if (!t_tc) begin
          t_dec = 1'b1;
        end else if ((state_q == DRIVE) && (BLANK > 0)) begin
          state_d = GAP;
          t_load  = 1'b1;
          t_val   = BLANK_LD;
        end else begin
          // Move to the next row's DRIVE; wrapping past the last row ends a frame.
          state_d = DRIVE;
          t_load  = 1'b1;
          t_val   = DWELL_LD;
          if (row_q == ROW_LAST) begin
            row_d  = '0;
            tick_d = 1'b1;
            if (frame_q == FRM_LAST) begin
              frame_d = '0;
              if (!bus.hold) sym_d = sym_q + 2'd1;
            end else begin
              frame_d = frame_q + FRM_W'(1);
            end
          end else begin
            row_d = row_q + 3'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        row_d   = '0;
      end
    endcase

    // Outputs follow the next state so they are registered alongside it.
    row_n_d = '1;
    col_d   = '0;
    if (state_d == DRIVE) begin
      row_n_d = row_sel_n(row_d);
      col_d   = bus.row_data[int'(row_d) * COLS +: COLS];
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      frame_q <= '0;
      sym_q   <= '0;
      tick_q  <= 1'b0;
      row_n_q <= '1;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      frame_q <= frame_d;
      sym_q   <= sym_d;
      tick_q  <= tick_d;
      row_n_q <= row_n_d;
      col_q   <= col_d;
    end
  end

  assign bus.sym_sel    = sym_q;
  assign bus.row_n      = row_n_q;
  assign bus.col        = col_q;
  assign bus.frame_tick = tick_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_matrix_row_scanner.sv
// Bench for matrix_row_scanner with DWELL=4, BLANK=1, FRAMES_PER_SYM=2.
// The reference model tracks a linear position within the frame and derives
// row, blanking and column expectations from it arithmetically.
module tb_matrix_row_scanner;
  import matrix_row_scanner_pkg::*;

  localparam int DW     = 4;
  localparam int BL     = 1;
  localparam int FPS    = 2;
  localparam int SLOT   = DW + BL;
  localparam int PERIOD = ROWS * SLOT;
  localparam int EW     = 2 + ROWS + COLS + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  matrix_row_scanner_if bus();

  matrix_row_scanner #(
    .DWELL          (DW),
    .BLANK          (BL),
    .FRAMES_PER_SYM (FPS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // model state
  bit m_active = 1'b0;
  int m_p      = 0;
  int m_frames = 0;
  int m_sym    = 0;
  bit m_tick   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n, input bit rnd_data);
    repeat (n) begin
      @(negedge clk);
      if (rnd_data) bus.row_data = {3'($urandom), $urandom};
    end
  endtask

  task automatic model_step();
    logic [DATA_W-1:0] rd;
    logic [ROWS-1:0]   rn;
    logic [COLS-1:0]   cl;
    int r;
    rd = bus.row_data;
    if (reset) begin
      m_active = 1'b0; m_p = 0; m_frames = 0; m_sym = 0; m_tick = 1'b0;
    end else if (!bus.en) begin
      m_active = 1'b0; m_p = 0; m_tick = 1'b0;
    end else if (!m_active) begin
      m_active = 1'b1; m_p = 0; m_tick = 1'b0;
    end else begin
      m_p++;
      m_tick = 1'b0;
      if (m_p == PERIOD) begin
        m_p = 0;
        m_tick = 1'b1;
        m_frames++;
        if (m_frames == FPS) begin
          m_frames = 0;
          if (!bus.hold) m_sym = (m_sym + 1) % 4;
        end
      end
    end
    rn = '1;
    cl = '0;
    if (m_active && ((m_p % SLOT) < DW)) begin
      r  = m_p / SLOT;
      rn = ~(ROWS'(1) << r);
      cl = rd[r * COLS +: COLS];
    end
    exp_q.push_back({2'(m_sym), rn, cl, m_tick});
  endtask

  // ---------------- main ----------------
  initial begin
    logic [EW-1:0] e;
    reset        = 1'b1;
    bus.en       = 1'b0;
    bus.hold     = 1'b0;
    bus.row_data = '0;

    fork
      forever begin
        @(posedge clk);
        model_step();
      end
      forever begin
        @(negedge clk);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("model", 32'({bus.sym_sel, bus.row_n, bus.col, bus.frame_tick}), 32'(e));
        end
      end
    join_none

    cycles(3, 0);
    check("rst_row_n", 32'(bus.row_n), 32'h7F);
    check("rst_col", 32'(bus.col), 32'h0);
    check("rst_sym", 32'(bus.sym_sel), 32'h0);
    check("rst_tick", 32'(bus.frame_tick), 32'h0);
    check("rst_state", 32'(bus.state_dbg), 32'(IDLE));

    // 1: first rows after enable
    reset        = 1'b0;
    bus.row_data = 35'h2AAAAAAAA;
    bus.en       = 1'b1;
    cycles(1, 0);
    check("r0_row_n", 32'(bus.row_n), 32'h7E);
    check("r0_col", 32'(bus.col), 32'h0A);
    cycles(3, 0);
    check("r0_last_row_n", 32'(bus.row_n), 32'h7E);
    cycles(1, 0);
    check("gap_row_n", 32'(bus.row_n), 32'h7F);
    check("gap_col", 32'(bus.col), 32'h0);
    cycles(1, 0);
    check("r1_row_n", 32'(bus.row_n), 32'h7D);
    check("r1_col", 32'(bus.col), 32'h15);

    // 2: first wrap at cycle 36
    cycles(29, 1);
    check("c35_tick", 32'(bus.frame_tick), 32'h0);
    cycles(1, 1);
    check("wrap1_tick", 32'(bus.frame_tick), 32'h1);
    check("wrap1_row_n", 32'(bus.row_n), 32'h7E);
    check("wrap1_sym", 32'(bus.sym_sel), 32'h0);
    cycles(1, 1);
    check("wrap1_tick_end", 32'(bus.frame_tick), 32'h0);

    // 3: second wrap at cycle 71, then sym wraps after 8 frames
    cycles(34, 1);
    check("wrap2_tick", 32'(bus.frame_tick), 32'h1);
    check("wrap2_sym", 32'(bus.sym_sel), 32'h1);
    cycles(PERIOD * 6, 1);
    check("wrap8_tick", 32'(bus.frame_tick), 32'h1);
    check("wrap8_sym", 32'(bus.sym_sel), 32'h0);

    // 4: hold across a symbol boundary
    bus.hold = 1'b1;
    cycles(PERIOD * 2, 1);
    check("hold_tick", 32'(bus.frame_tick), 32'h1);
    check("hold_sym", 32'(bus.sym_sel), 32'h0);
    bus.hold = 1'b0;
    cycles(PERIOD * 2, 1);
    check("unhold_sym", 32'(bus.sym_sel), 32'h1);

    // 5: drop en during row 3's drive
    cycles(16, 1);
    check("r3_row_n", 32'(bus.row_n), 32'h77);
    bus.en = 1'b0;
    cycles(1, 1);
    check("abort_row_n", 32'(bus.row_n), 32'h7F);
    check("abort_col", 32'(bus.col), 32'h0);
    cycles(3, 1);
    bus.en = 1'b1;
    cycles(1, 1);
    check("reen_row_n", 32'(bus.row_n), 32'h7E);
    check("reen_tick", 32'(bus.frame_tick), 32'h0);
    check("reen_sym", 32'(bus.sym_sel), 32'h1);

    // random phase: occasional enable drops, random hold, random patterns
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      bus.row_data = {3'($urandom), $urandom};
      bus.en       = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 49) == 0) bus.hold = 1'($urandom_range(0, 1));
    end

    // 6: reset mid-gap with sym_sel=2
    bus.hold = 1'b0;
    bus.en   = 1'b0;
    reset    = 1'b1;
    cycles(2, 0);
    reset  = 1'b0;
    bus.en = 1'b1;
    cycles(1, 1);
    cycles(PERIOD * 4, 1);
    check("pre_rst_sym", 32'(bus.sym_sel), 32'h2);
    cycles(4, 1);
    check("pre_rst_gap", 32'(bus.row_n), 32'h7F);
    reset = 1'b1;
    cycles(1, 1);
    check("rst2_row_n", 32'(bus.row_n), 32'h7F);
    check("rst2_col", 32'(bus.col), 32'h0);
    check("rst2_sym", 32'(bus.sym_sel), 32'h0);
    check("rst2_state", 32'(bus.state_dbg), 32'(IDLE));
    cycles(1, 1);
    check("rst2_hold_state", 32'(bus.state_dbg), 32'(IDLE));
    reset = 1'b0;
    cycles(1, 1);
    check("post_rst_row_n", 32'(bus.row_n), 32'h7E);
    cycles(10, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
